muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS datapath, alongside the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and holds the results in architectural HI/LO registers.
- Supports direct MTHI/MTLO writes.
- Uses a start/busy/done handshake so the pipeline can stall on mfhi/mflo while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal values are 8 or more, even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only while busy=0
- funct  input  6  MIPS funct code: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI, MTLO data)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated by a mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; hi=0; lo=0; counter and internal registers cleared. A reset mid-operation abandons the operation with no HI/LO write.
- States: IDLE, RUN, FIX.
- IDLE, start=1, funct in {MULT, MULTU, DIV, DIVU} (edge N):
  - Latch operand magnitudes (absolute values for signed ops) and the result sign flags.
  - counter=WIDTH; state goes to RUN; busy=1 from the cycle after N.
- IDLE, start=1, funct=MTHI or MTLO: hi (or lo) <= a on that edge; no busy; no done.
- IDLE, start=1, any other funct: ignored; no state change.
- RUN: one iteration per edge; counter decrements; the edge on which counter reaches 0 moves to FIX.
  - Multiply: shift-add. Accumulate the 2*WIDTH-bit product of the magnitudes.
  - Divide: restoring. Each iteration shifts the remainder left by 1, subtracts the divisor, and keeps the difference if it is non-negative; the quotient bit is set to 1 on keep.
- FIX (one cycle): the edge leaving FIX writes hi/lo, pulses done=1 for exactly the following cycle, deasserts busy, and returns to IDLE.
- Latency: start edge N → done high and hi/lo valid in the cycle after edge N+WIDTH+1 (N+33 for WIDTH=32). A back-to-back start is accepted in that done cycle.
- Multiply result: {hi,lo} = full product.
  - Signed: negate the 2*WIDTH-bit product when the operand signs differ.
- Divide result: lo=quotient, hi=remainder.
  - Signed: quotient negated when the operand signs differ; remainder takes the dividend's sign.
- Most-negative / -1 (signed divide): lo=100..0, hi=0 (natural wrap, no trap).
- Divide by zero (DIV or DIVU): hi=a, lo=all ones; full latency still applies.
- Any start, MTHI or MTLO presented while busy=1 is ignored and causes no error.
- hi/lo hold their values at all times other than the defined write edges.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in RUN, for multiply only, an edge that sees the remaining multiplier bits all zero moves directly to FIX without iterating. Latency becomes data-dependent: with b=3, done follows edge N+4; with b=0, done follows edge N+2. Divide latency is unchanged.
- Undefined: fixed latency of WIDTH+1 edges for every operation.
- Results are identical with or without the macro.

Test Plan:
- MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001, with done exactly 33 edges after the start edge (macro off).
- MULT a=FFFFFFFD (-3), b=00000005 → hi=FFFFFFFF, lo=FFFFFFF1; DIV a=FFFFFFF9 (-7), b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=12345678, b=0 → hi=12345678, lo=FFFFFFFF; DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- MTHI a=CAFEF00D while idle → hi=CAFEF00D the next cycle, with no busy and no done. A second start and an MTLO issued mid-MULT are ignored: hi/lo are written only by the first op.
- Assert rst 10 cycles into a DIVU → busy=0, done=0, hi=lo=0 immediately; a new MULTU 6×7 then gives lo=0000002A, hi=0.
- With MULDIV_EARLY_OUT_EN defined: MULTU 7×3 → lo=00000015, done after edge N+4; DIVU still takes 33 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and a start/busy/done handshake.
// Optional macro MULDIV_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 op_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       div_top, div_diff;
  logic                 div_keep;
  logic                 early_out;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = !is_div_q && (mplier_q == '0);
`else
  assign early_out = 1'b0;
`endif

  // Restoring divide: acc holds {remainder, dividend-bits-becoming-quotient}
  assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_top - {1'b0, mcand_q[WIDTH-1:0]};
  assign div_keep = !div_diff[WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    op_signed = (funct == F_MULT) || (funct == F_DIV);
    a_neg     = op_signed && a[WIDTH-1];
    b_neg     = op_signed && b[WIDTH-1];
    a_mag     = magnitude(a, op_signed);
    b_mag     = magnitude(b, op_signed);

    case (state_q)
      IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU: begin
              is_div_d = 1'b0;
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, a_mag};
              mplier_d = b_mag;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = RUN;
            end
            F_DIV, F_DIVU: begin
              is_div_d = 1'b1;
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              mcand_d  = {{WIDTH{1'b0}}, b_mag};
              mplier_d = '0;
              // Zero divisor: keep quotient all-ones and let the remainder restore to a
              neg_lo_d = (a_neg ^ b_neg) && (b != '0);
              neg_hi_d = a_neg;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = RUN;
            end
            F_MTHI:  hi_d = a;
            F_MTLO:  lo_d = a;
            default: ;
          endcase
        end
      end

      RUN: begin
        if (early_out) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
          if (is_div_q) begin
            acc_d = {(div_keep ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_keep};
          end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
        end
      end

      FIX: begin
        if (is_div_q) begin
          lo_d = negate_w(acc_q[WIDTH-1:0], neg_lo_q);
          hi_d = negate_w(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
        end else begin
          {hi_d, lo_d} = negate_2w(acc_q, neg_lo_q);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
